// File: rtl/wb_write_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue_if
// Description : Bundle of the write-back queue's bus signals. It carries the
//               producer valid/ready handshake (in_*), the register file
//               write port (WE3/A3/WD3) and the two operand-forwarding query
//               ports (q_*).
//               slave  : the queue's view of the bundle
//               master : the surrounding datapath's view of the bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    // Producer handshake
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;

    // Register file write port
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;

    // Forwarding queries
    logic [AW-1:0] q_addr1;
    logic [AW-1:0] q_addr2;
    logic          q_hit1;
    logic          q_hit2;
    logic [DW-1:0] q_data1;
    logic [DW-1:0] q_data2;

    modport slave (
        input  in_valid, in_rd, in_data, q_addr1, q_addr2,
        output in_ready, WE3, A3, WD3, q_hit1, q_hit2, q_data1, q_data2
    );

    modport master (
        output in_valid, in_rd, in_data, q_addr1, q_addr2,
        input  in_ready, WE3, A3, WD3, q_hit1, q_hit2, q_data1, q_data2
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue
// Description : In-order write-back queue for the integer register file.
//               It buffers results handed over by the datapath and drains
//               one entry per cycle into the register file write port. Two
//               query ports report the youngest still-queued write to a
//               given register so that operand fetch can forward it.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous, active-high
//               bus    - wb_write_queue_if.slave (handshake, write port,
//                        query ports)
//               count  - number of valid entries
//               empty  - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  wire                       clk,
    input  wire                       reset,
    wb_write_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam int              c_CW   = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // ------------------------------------------------------------------------
    // Storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [AW-1:0]   r_rd   [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    logic            w_ready;
    logic            w_nonempty;
    logic            w_push;
    logic            w_pop;

    // Ready depends only on reset and occupancy. A pop in the same cycle
    // does not free a slot for the producer, so a full queue never passes
    // a result straight through.
    assign w_ready    = !reset && (r_count < c_FULL);
    assign w_nonempty = (r_count != '0);
    // Writes to x0 complete the handshake but are never stored.
    assign w_push     = bus.in_valid && w_ready && (bus.in_rd != '0);
    // The register file always accepts, so the head leaves every cycle the
    // queue holds something.
    assign w_pop      = w_nonempty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // Head and tail never coincide while both a push and a pop are
            // possible (that needs 0 < count < DEPTH), so the two valid-bit
            // updates below never touch the same entry.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The payload needs no reset: it is only visible through the valid bits
    // and the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= bus.in_rd;
            r_data[r_tail] <= bus.in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Register file write port
    // ------------------------------------------------------------------------
    assign bus.in_ready = w_ready;
    assign bus.WE3      = w_nonempty;
    assign bus.A3       = w_nonempty ? r_rd[r_head]   : '0;
    assign bus.WD3      = w_nonempty ? r_data[r_head] : '0;
    assign count        = r_count;
    assign empty        = !w_nonempty;

    // ------------------------------------------------------------------------
    // Forwarding queries
    // ------------------------------------------------------------------------
    // Entries are scanned oldest (head) to youngest, so the last match seen
    // is the youngest one. Only stored state is searched; the same-cycle
    // producer inputs are deliberately ignored. Result is {hit, data}.
    function automatic logic [DW:0] f_lookup(input logic [AW-1:0] addr);
        logic [c_PW-1:0] idx;
        logic [DW:0]     res;
        res = '0;
        if (addr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = r_head + c_PW'(i);
                if (r_valid[idx] && (r_rd[idx] == addr)) begin
                    res = {1'b1, r_data[idx]};
                end
            end
        end
        return res;
    endfunction

    logic [DW:0] w_q1;
    logic [DW:0] w_q2;

    always_comb begin
        w_q1 = f_lookup(bus.q_addr1);
        w_q2 = f_lookup(bus.q_addr2);
    end

    assign bus.q_hit1  = w_q1[DW];
    assign bus.q_data1 = w_q1[DW-1:0];
    assign bus.q_hit2  = w_q2[DW];
    assign bus.q_data2 = w_q2[DW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Self-checking bench for wb_write_queue. A queue-based model
//               of the buffer is updated on each rising edge and every DUT
//               output is compared against it on the falling edge. Directed
//               scenarios add literal expectations for the key cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] count;
    logic          empty;

    wb_write_queue_if #(.AW(AW), .DW(DW)) bus ();

    wb_write_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .count (count),
        .empty (empty)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   mvalid = 1'b0;
    ent_t mq[$];
    ent_t dut_log[$];
    int   log_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Youngest queued write to addr; x0 never hits.
    function automatic void lookup(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == a) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endfunction

    // Model: on each edge the oldest entry leaves if present, and an accepted
    // non-x0 result joins the back. Readiness is judged before the edge.
    bit m_rdy;
    always @(posedge clk) begin
        m_rdy = !reset && (mq.size() < DEPTH);
        if (reset) begin
            mq.delete();
            mvalid = 1'b1;
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (bus.in_valid && m_rdy && bus.in_rd != '0)
                mq.push_back(ent_t'({bus.in_rd, bus.in_data}));
        end
    end

    bit            e_h1, e_h2;
    logic [DW-1:0] e_d1, e_d2;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd3;
    always @(negedge clk) begin
        if (mvalid) begin
            lookup(bus.q_addr1, e_h1, e_d1);
            lookup(bus.q_addr2, e_h2, e_d2);
            e_a3  = '0;
            e_wd3 = '0;
            if (mq.size() > 0) begin
                e_a3  = mq[0].rd;
                e_wd3 = mq[0].data;
            end
            chk("in_ready", bus.in_ready, !reset && (mq.size() < DEPTH));
            chk("WE3",      bus.WE3,      mq.size() > 0);
            chk("A3",       bus.A3,       e_a3);
            chk("WD3",      bus.WD3,      e_wd3);
            chk("count",    count,        mq.size());
            chk("empty",    empty,        mq.size() == 0);
            chk("q_hit1",   bus.q_hit1,   e_h1);
            chk("q_data1",  bus.q_data1,  e_d1);
            chk("q_hit2",   bus.q_hit2,   e_h2);
            chk("q_data2",  bus.q_data2,  e_d2);
            if (bus.WE3) begin
                dut_log.push_back(ent_t'({bus.A3, bus.WD3}));
                log_cyc.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  s;
    int  m;
    int  tries;
    bit  acc;

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_rd    = AW'(3);
        bus.in_data  = 32'h0000_0055;
        bus.q_addr1  = '0;
        bus.q_addr2  = '0;

        // Reset held with a pending offer
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_WE3",      bus.WE3,      1'b0);
        chk("rst_count",    count,        0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_ready", bus.in_ready, 1'b1);
        chk("post_rst_empty", empty,        1'b1);

        // Single write
        bus.in_valid = 1'b1;
        bus.in_rd    = AW'(5);
        bus.in_data  = 32'hDEAD_BEEF;
        bus.q_addr1  = AW'(5);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("single_WE3",   bus.WE3,     1'b1);
        chk("single_A3",    bus.A3,      5);
        chk("single_WD3",   bus.WD3,     32'hDEAD_BEEF);
        chk("single_hit1",  bus.q_hit1,  1'b1);
        chk("single_data1", bus.q_data1, 32'hDEAD_BEEF);
        tick();
        chk("single_empty", empty,      1'b1);
        chk("single_WE3_0", bus.WE3,    1'b0);
        chk("single_hit_0", bus.q_hit1, 1'b0);

        // Write to x0 is swallowed
        s            = dut_log.size();
        bus.q_addr1  = '0;
        bus.in_valid = 1'b1;
        bus.in_rd    = '0;
        bus.in_data  = 32'h1234_5678;
        #1;
        chk("x0_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("x0_count", count,      0);
        chk("x0_WE3",   bus.WE3,    1'b0);
        chk("x0_hit1",  bus.q_hit1, 1'b0);
        tick();
        tick();
        chk("x0_nowrite", dut_log.size() - s, 0);

        // Back-to-back stream of six writes
        s = dut_log.size();
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_rd    = AW'(i);
            bus.in_data  = DW'(i) * 32'h11;
            tries        = 0;
            acc          = 1'b0;
            while (!acc) begin
                acc = bus.in_ready;
                tick();
                tries++;
                if (!acc && tries > 20) begin
                    chk("fill_timeout", 1'b0, 1'b1);
                    acc = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("fill_len", dut_log.size() - s, 6);
        if (dut_log.size() - s >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("fill_rd",   dut_log[s+k].rd,   k + 1);
                chk("fill_data", dut_log[s+k].data, (k + 1) * 32'h11);
                if (k > 0) chk("fill_gap", log_cyc[s+k] - log_cyc[s+k-1], 1);
            end
        end

        // Youngest-match forwarding on query port 2
        bus.q_addr2  = AW'(7);
        bus.in_valid = 1'b1;
        bus.in_rd    = AW'(7);
        bus.in_data  = 32'hA;
        tick();
        bus.in_rd    = AW'(3);
        bus.in_data  = 32'hB;
        #1;
        chk("fwd_hit_a",  bus.q_hit2,  1'b1);
        chk("fwd_data_a", bus.q_data2, 32'hA);
        tick();
        bus.in_rd    = AW'(7);
        bus.in_data  = 32'hC;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("fwd_hit_c",  bus.q_hit2,  1'b1);
        chk("fwd_data_c", bus.q_data2, 32'hC);
        tick();
        chk("fwd_hit_gone",  bus.q_hit2,  1'b0);
        chk("fwd_data_gone", bus.q_data2, 32'h0);
        bus.q_addr2 = '0;

        // Reset in the middle of a stream
        for (int i = 9; i <= 11; i++) begin
            bus.in_valid = 1'b1;
            bus.in_rd    = AW'(i);
            bus.in_data  = DW'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        chk("mid_rst_count", count,   0);
        chk("mid_rst_WE3",   bus.WE3, 1'b0);
        reset        = 1'b0;
        m            = dut_log.size();
        bus.in_valid = 1'b1;
        bus.in_rd    = AW'(12);
        bus.in_data  = 32'h1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_A3",  bus.A3,  12);
        chk("mid_rst_WD3", bus.WD3, 32'h1);
        tick();
        tick();
        chk("mid_rst_len", dut_log.size() - m, 1);
        if (dut_log.size() > m) chk("mid_rst_first", dut_log[m].rd, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
